// File: rtl/axi_decerr_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_decerr_slave                                              |
// | Purpose  : AXI4 default slave; absorbs any burst and answers DECERR.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module axi_decerr_slave #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         ID_WIDTH    = 8,
    parameter logic [1:0] RESP        = 2'b11,
    parameter int         COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [ID_WIDTH-1:0]    s_axi_awid,
    input  logic [7:0]             s_axi_awlen,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic                   s_axi_wlast,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [ID_WIDTH-1:0]    s_axi_bid,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,

    input  logic [ID_WIDTH-1:0]    s_axi_arid,
    input  logic [7:0]             s_axi_arlen,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [ID_WIDTH-1:0]    s_axi_rid,
    output logic [DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rlast,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,

    output logic [COUNT_WIDTH-1:0] wr_err_count,
    output logic [COUNT_WIDTH-1:0] rd_err_count
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_DATA = 2'd1;

    localparam logic [COUNT_WIDTH-1:0] c_count_max = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] c_count_one = COUNT_WIDTH'(1);

    logic [1:0]             r_wstate;
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_bvalid;
    logic [ID_WIDTH-1:0]    r_bid;
    logic [1:0]             r_bresp;

    logic [1:0]             r_rstate;
    logic                   r_arready;
    logic                   r_rvalid;
    logic                   r_rlast;
    logic [ID_WIDTH-1:0]    r_rid;
    logic [1:0]             r_rresp;
    logic [7:0]             r_cnt;

    logic [COUNT_WIDTH-1:0] r_wr_count;
    logic [COUNT_WIDTH-1:0] r_rd_count;

    logic                   w_b_done;
    logic                   w_r_done;
    logic                   w_unused_awlen;

    // Write burst end is decided by wlast alone, so awlen has no function here.
    assign w_unused_awlen = ^s_axi_awlen;

    assign w_b_done = (r_wstate == W_RESP) && r_bvalid && s_axi_bready;
    assign w_r_done = (r_rstate == R_DATA) && r_rvalid && s_axi_rready && (r_cnt == 8'd0);

    // Write channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= 2'b00;
        end else begin
            r_bresp <= RESP;
            case (r_wstate)
                W_IDLE: begin
                    if (s_axi_awvalid && r_awready) begin
                        r_bid     <= s_axi_awid;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid && r_wready && s_axi_wlast) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (r_bvalid && s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel; r_cnt holds the number of beats still to follow the current one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= 2'b00;
            r_cnt     <= 8'd0;
        end else begin
            r_rresp <= RESP;
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi_arvalid && r_arready) begin
                        r_rid     <= s_axi_arid;
                        r_cnt     <= s_axi_arlen;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rlast   <= (s_axi_arlen == 8'd0);
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_rvalid && s_axi_rready) begin
                        if (r_cnt == 8'd0) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt - 8'd1;
                            r_rlast <= (r_cnt == 8'd1);
                        end
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating completion counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            if (w_b_done && (r_wr_count != c_count_max)) begin
                r_wr_count <= r_wr_count + c_count_one;
            end
            if (w_r_done && (r_rd_count != c_count_max)) begin
                r_rd_count <= r_rd_count + c_count_one;
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = '0;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rvalid  = r_rvalid;
    assign wr_err_count  = r_wr_count;
    assign rd_err_count  = r_rd_count;

endmodule
`default_nettype wire

// File: tb/tb_axi_decerr_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_decerr_slave                                           |
// | Purpose  : Random-stimulus scoreboard bench for axi_decerr_slave.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_axi_decerr_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awid = '0, awlen = '0, arid = '0, arlen = '0;
    logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready, rready;
    logic        bready_fixed = 1'b1, rready_fixed = 1'b1;
    logic        bready_rand = 1'b0, rready_rand = 1'b0;

    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [7:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [15:0] wr_cnt, rd_cnt;

    logic        d2_awready, d2_wready, d2_bvalid, d2_arready, d2_rvalid, d2_rlast;
    logic [7:0]  d2_bid, d2_rid;
    logic [1:0]  d2_bresp, d2_rresp;
    logic [31:0] d2_rdata;
    logic [1:0]  d2_wr_cnt, d2_rd_cnt;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected B ids, and expected R beats as {last, id}
    logic [7:0] bq[$];
    logic [8:0] rq[$];
    int exp_wr = 0;
    int exp_rd = 0;

    always #5 clk = ~clk;

    axi_decerr_slave #(.DATA_WIDTH(32), .ID_WIDTH(8), .RESP(2'b11), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .wr_err_count(wr_cnt), .rd_err_count(rd_cnt)
    );

    axi_decerr_slave #(.DATA_WIDTH(32), .ID_WIDTH(8), .RESP(2'b11), .COUNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awvalid(awvalid), .s_axi_awready(d2_awready),
        .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(d2_wready),
        .s_axi_bid(d2_bid), .s_axi_bresp(d2_bresp), .s_axi_bvalid(d2_bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid), .s_axi_arready(d2_arready),
        .s_axi_rid(d2_rid), .s_axi_rdata(d2_rdata), .s_axi_rresp(d2_rresp), .s_axi_rlast(d2_rlast),
        .s_axi_rvalid(d2_rvalid), .s_axi_rready(rready),
        .wr_err_count(d2_wr_cnt), .rd_err_count(d2_rd_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake at %0t", name, $time);
    endtask

    function automatic logic [63:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    // Ready drivers: fixed or random, updated just after each rising edge
    initial begin
        bready = 1'b0;
        rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bready = bready_rand ? 1'($urandom_range(0, 1)) : bready_fixed;
            rready = rready_rand ? 1'($urandom_range(0, 1)) : rready_fixed;
        end
    end

    // Monitor: counters, hold stability, and every B/R handshake against the scoreboard
    initial begin
        logic       b_hold, r_hold, hold_rlast;
        logic [7:0] hold_bid, hold_rid, eb;
        logic [8:0] er;
        b_hold = 1'b0; r_hold = 1'b0; hold_rlast = 1'b0; hold_bid = '0; hold_rid = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bq.delete();
                rq.delete();
                exp_wr = 0;
                exp_rd = 0;
                b_hold = 1'b0;
                r_hold = 1'b0;
            end else begin
                chk("wr_err_count", 64'(wr_cnt), sat(exp_wr, 16));
                chk("rd_err_count", 64'(rd_cnt), sat(exp_rd, 16));
                chk("wr_err_count_w2", 64'(d2_wr_cnt), sat(exp_wr, 2));
                chk("rd_err_count_w2", 64'(d2_rd_cnt), sat(exp_rd, 2));
                if (b_hold) begin
                    chk("b_hold_valid", 64'(bvalid), 64'd1);
                    chk("b_hold_id", 64'(bid), 64'(hold_bid));
                end
                if (r_hold) begin
                    chk("r_hold_valid", 64'(rvalid), 64'd1);
                    chk("r_hold_id", 64'(rid), 64'(hold_rid));
                    chk("r_hold_last", 64'(rlast), 64'(hold_rlast));
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        chk("b_unexpected", 64'(bvalid), 64'd0);
                    end else begin
                        eb = bq.pop_front();
                        chk("bid", 64'(bid), 64'(eb));
                        chk("bresp", 64'(bresp), 64'd3);
                    end
                    exp_wr++;
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        chk("r_unexpected", 64'(rvalid), 64'd0);
                    end else begin
                        er = rq.pop_front();
                        chk("rid", 64'(rid), 64'(er[7:0]));
                        chk("rlast", 64'(rlast), 64'(er[8]));
                        chk("rdata", 64'(rdata), 64'd0);
                        chk("rresp", 64'(rresp), 64'd3);
                        if (er[8]) exp_rd++;
                    end
                end
                b_hold     = bvalid && !bready;
                hold_bid   = bid;
                r_hold     = rvalid && !rready;
                hold_rid   = rid;
                hold_rlast = rlast;
            end
        end
    end

    task automatic do_write(input logic [7:0] id, input logic [7:0] len, input int nbeats);
        int t;
        @(posedge clk); #1;
        awid = id; awlen = len; awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 50) begin t++; @(negedge clk); end
        if (!awready) begin fail("aw_timeout"); awvalid = 1'b0; return; end
        @(posedge clk);
        bq.push_back(id);
        #1 awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            wvalid = 1'b1;
            wlast  = (b == nbeats - 1);
            t = 0;
            @(negedge clk);
            while (!wready && t < 50) begin t++; @(negedge clk); end
            if (!wready) begin fail("w_timeout"); wvalid = 1'b0; wlast = 1'b0; return; end
            @(posedge clk); #1;
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
        @(negedge clk);
        chk("b_latency", 64'(bvalid), 64'd1);
        t = 0;
        while (!(bvalid && bready) && t < 200) begin
            chk("aw_low_in_resp", 64'(awready), 64'd0);
            t++;
            @(negedge clk);
        end
        if (!(bvalid && bready)) begin fail("b_timeout"); return; end
        @(negedge clk);
        chk("aw_reassert", 64'(awready), 64'd1);
        chk("b_drop", 64'(bvalid), 64'd0);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [7:0] len);
        int t, beats, cyc;
        @(posedge clk); #1;
        arid = id; arlen = len; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin t++; @(negedge clk); end
        if (!arready) begin fail("ar_timeout"); arvalid = 1'b0; return; end
        @(posedge clk);
        for (int i = 0; i <= int'(len); i++) rq.push_back({(i == int'(len)), id});
        #1 arvalid = 1'b0;
        @(negedge clk);
        chk("r_first_latency", 64'(rvalid), 64'd1);
        beats = 0;
        cyc = 0;
        forever begin
            chk("ar_low_in_burst", 64'(arready), 64'd0);
            if (rvalid && rready) beats++;
            cyc++;
            if (beats == int'(len) + 1 || cyc > 3000) break;
            @(negedge clk);
        end
        if (beats != int'(len) + 1) begin fail("r_timeout"); return; end
        if (!rready_rand) chk("r_beat_cycles", 64'(cyc), 64'(int'(len) + 1));
        @(negedge clk);
        chk("ar_reassert", 64'(arready), 64'd1);
        chk("r_drop", 64'(rvalid), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] sat_seq [5];
        int t, beats;
        sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3; sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_counts", 64'({wr_cnt, rd_cnt}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("awready_after_rst_0", 64'(awready), 64'd0);
        @(negedge clk);
        chk("awready_after_rst_1", 64'(awready), 64'd1);
        chk("arready_after_rst_1", 64'(arready), 64'd1);

        // Single-beat write, then a 4-beat read
        do_write(8'h15, 8'd0, 1);
        chk("t1_wr_count", 64'(wr_cnt), 64'd1);
        do_read(8'h2A, 8'd3);
        chk("t2_rd_count", 64'(rd_cnt), 64'd1);

        // Response back-pressure, and wlast deciding burst end regardless of awlen
        bready_fixed = 1'b0;
        fork
            do_write(8'h5A, 8'd7, 2);
            begin
                t = 0;
                @(negedge clk);
                while (!bvalid && t < 100) begin t++; @(negedge clk); end
                repeat (5) begin
                    @(negedge clk);
                    chk("t3_awready_held", 64'(awready), 64'd0);
                end
                bready_fixed = 1'b1;
            end
        join

        // 256-beat read under random rready
        rready_rand = 1'b1;
        do_read(8'h77, 8'd255);
        rready_rand = 1'b0;
        chk("t3_rq_drained", 64'(rq.size()), 64'd0);

        // Random concurrent traffic
        rready_rand = 1'b1;
        bready_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] wl, rl;
            wl = 8'($urandom_range(0, 15));
            rl = 8'($urandom_range(0, 15));
            fork
                do_write(8'($urandom), wl, int'(wl) + 1);
                do_read(8'($urandom), rl);
            join
        end
        rready_rand = 1'b0;
        bready_rand = 1'b0;

        // Reset during beat 3 of an 8-beat read
        @(posedge clk); #1;
        arid = 8'h33; arlen = 8'd7; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin t++; @(negedge clk); end
        @(posedge clk);
        for (int i = 0; i < 8; i++) rq.push_back({(i == 7), 8'h33});
        #1 arvalid = 1'b0;
        beats = 0;
        t = 0;
        while (beats < 2 && t < 50) begin
            @(negedge clk);
            if (rvalid && rready) beats++;
            t++;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_rvalid", 64'(rvalid), 64'd0);
        chk("t5_rlast", 64'(rlast), 64'd0);
        chk("t5_counts", 64'({wr_cnt, rd_cnt}), 64'd0);
        chk("t5_readies", 64'({awready, arready}), 64'd0);
        @(negedge clk);
        chk("t5_arready", 64'(arready), 64'd1);
        chk("t5_awready", 64'(awready), 64'd1);
        do_read(8'h44, 8'd5);
        chk("t5_fresh_rd_count", 64'(rd_cnt), 64'd1);

        // Write and read issued in the same cycle
        do_reset();
        fork
            do_write(8'hC3, 8'd7, 8);
            do_read(8'h3C, 8'd7);
        join
        chk("t4_wr_count", 64'(wr_cnt), 64'd1);
        chk("t4_rd_count", 64'(rd_cnt), 64'd1);

        // Narrow counter saturation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_write(8'(i + 1), 8'd0, 1);
            chk("t6_w2_count", 64'(d2_wr_cnt), 64'(sat_seq[i]));
        end

        repeat (3) @(negedge clk);
        chk("end_bq_empty", 64'(bq.size()), 64'd0);
        chk("end_rq_empty", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
